dmem_arbiter: RTL and testbench

Two-port arbiter and sequencer for the single data-memory port. It sits between the MEM stage (port C, core load/store) and an auxiliary requester (port A, DMA/debug loader), and drives `dmem_*` toward data memory. It latches one request at a time, holds it until `dmem_ready`, and returns a completion pulse to the owner. It also raises `core_stall` to freeze the pipeline while a core access is outstanding.

---
 rtl/dmem_arbiter_if.sv | 34 +++
 rtl/dmem_arbiter.sv | 79 +++++++
 tb/tb_dmem_arbiter.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: bundle of core port (c_*), aux port (a_*), core_stall and memory-side dmem_* signals
// slave modport: arbiter side; master modport: requesters plus data memory (testbench side).
interface dmem_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                    c_req, c_wen, c_done;
  logic [ADDR_WIDTH-1:0]   c_addr;
  logic [DATA_WIDTH-1:0]   c_wdata, c_rdata;
  logic [DATA_WIDTH/8-1:0] c_byte_en;
  logic                    a_req, a_wen, a_done;
  logic [ADDR_WIDTH-1:0]   a_addr;
  logic [DATA_WIDTH-1:0]   a_wdata, a_rdata;
  logic [DATA_WIDTH/8-1:0] a_byte_en;
  logic                    core_stall;
  logic [ADDR_WIDTH-1:0]   dmem_addr;
  logic [DATA_WIDTH-1:0]   dmem_wdata, dmem_rdata;
  logic [DATA_WIDTH/8-1:0] dmem_byte_en;
  logic                    dmem_wen, dmem_ren, dmem_ready;
  modport slave (
    input  c_req, c_wen, c_addr, c_wdata, c_byte_en,
    input  a_req, a_wen, a_addr, a_wdata, a_byte_en,
    input  dmem_rdata, dmem_ready,
    output c_done, c_rdata, a_done, a_rdata, core_stall,
    output dmem_addr, dmem_wdata, dmem_byte_en, dmem_wen, dmem_ren
  );
  modport master (
    output c_req, c_wen, c_addr, c_wdata, c_byte_en,
    output a_req, a_wen, a_addr, a_wdata, a_byte_en,
    output dmem_rdata, dmem_ready,
    input  c_done, c_rdata, a_done, a_rdata, core_stall,
    input  dmem_addr, dmem_wdata, dmem_byte_en, dmem_wen, dmem_ren
  );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: arbitrates core (C) and aux (A) requests onto the single data-memory port
// Ports: clk; rst_n (async, active-low); bus (dmem_arbiter_if.slave) carrying the c_*/a_*
// request ports with done/rdata returns, core_stall, and the latched dmem_* memory interface.
module dmem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_WAIT   = 4
) (
  input logic           clk,
  input logic           rst_n,
  dmem_arbiter_if.slave bus
);
  localparam int BW = DATA_WIDTH / 8;
  localparam int WW = $clog2(MAX_WAIT + 1);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t                state_q, state_d;
  logic [WW-1:0]         wait_cnt_q, wait_cnt_d;
  logic                  wen_q, wen_d;
  logic                  owner_q, owner_d;  // 1 = port A owns the access
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [BW-1:0]         be_q, be_d;
  logic                  grant_a, busy, done;
  assign busy = state_q == BUSY;
  assign done = busy & bus.dmem_ready;
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    wen_d      = wen_q;
    owner_d    = owner_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    be_d       = be_q;
    grant_a    = bus.a_req & (~bus.c_req | (wait_cnt_q == WW'(MAX_WAIT)));
    if (!busy) begin
      // a C grant with a_req pending only happens below MAX_WAIT, so no explicit saturation is needed
      wait_cnt_d = (grant_a | ~bus.a_req) ? '0 : wait_cnt_q + 1'b1;
      if (bus.c_req | bus.a_req) begin
        state_d = BUSY;
        owner_d = grant_a;
        wen_d   = grant_a ? bus.a_wen     : bus.c_wen;
        addr_d  = grant_a ? bus.a_addr    : bus.c_addr;
        wdata_d = grant_a ? bus.a_wdata   : bus.c_wdata;
        be_d    = grant_a ? bus.a_byte_en : bus.c_byte_en;
      end
    end else if (done) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      wait_cnt_q <= '0;
      wen_q      <= 1'b0;
      owner_q    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      wen_q      <= wen_d;
      owner_q    <= owner_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      be_q       <= be_d;
    end
  end
  assign bus.dmem_wen     = busy & wen_q;
  assign bus.dmem_ren     = busy & ~wen_q;
  assign bus.dmem_addr    = addr_q;
  assign bus.dmem_wdata   = wdata_q;
  assign bus.dmem_byte_en = be_q;
  assign bus.c_done       = done & ~owner_q;
  assign bus.a_done       = done & owner_q;
  assign bus.c_rdata      = (bus.c_done & ~wen_q) ? bus.dmem_rdata : '0;
  assign bus.a_rdata      = (bus.a_done & ~wen_q) ? bus.dmem_rdata : '0;
  assign bus.core_stall   = bus.c_req & ~bus.c_done;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed scoreboard bench for dmem_arbiter with a latency-programmable memory responder
module tb_dmem_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  dmem_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) b();
  dmem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_WAIT(4)) dut (.clk(clk), .rst_n(rst_n), .bus(b));
  typedef struct {logic port; logic [31:0] addr; logic [31:0] rdata;} exp_t;
  exp_t sb[$];
  int   n_vec = 0, n_err = 0, done_cnt = 0, ren_cnt = 0, pushed = 0;
  int   lat = 0, cnt = 0;
  logic ready_hold = 1'b0, ready_idle = 1'b0, strobe;
  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return (a == 32'h40) ? 32'h12345678 : {a[15:0], ~a[15:0]};
  endfunction
  assign strobe       = b.dmem_wen | b.dmem_ren;
  assign b.dmem_ready = ~ready_hold & (ready_idle | (strobe & (cnt == lat)));
  assign b.dmem_rdata = mem_f(b.dmem_addr);
  always @(posedge clk) cnt <= (strobe & ~b.dmem_ready) ? cnt + 1 : 0;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic push(input logic p, input logic [31:0] a, input logic wen);
    sb.push_back('{p, a, wen ? 32'h0 : mem_f(a)});
    pushed++;
  endtask
  task automatic wait_done(input int target, input int budget);
    int i = 0;
    while (done_cnt < target && i < budget) begin
      tick();
      i++;
    end
    chk("done_within_budget", 64'(done_cnt >= target), 64'd1);
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (b.dmem_ren) ren_cnt++;
    if (b.c_done | b.a_done) begin
      chk("single_done", 64'(b.c_done & b.a_done), 64'd0);
      chk("sb_has_entry", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("done_port", 64'(b.a_done), 64'(e.port));
        chk("done_addr", 64'(b.dmem_addr), 64'(e.addr));
        chk("done_rdata", 64'(e.port ? b.a_rdata : b.c_rdata), 64'(e.rdata));
        chk("other_rdata_zero", 64'(e.port ? b.c_rdata : b.a_rdata), 64'd0);
      end
      done_cnt++;
    end
  end
  initial begin
    {b.c_req, b.c_wen, b.c_addr, b.c_wdata, b.c_byte_en} = '0;
    {b.a_req, b.a_wen, b.a_addr, b.a_wdata, b.a_byte_en} = '0;
    b.c_req = 1'b1;
    @(negedge clk);
    chk("rst_wen", 64'(b.dmem_wen), 64'd0);
    chk("rst_ren", 64'(b.dmem_ren), 64'd0);
    chk("rst_addr", 64'(b.dmem_addr), 64'd0);
    chk("rst_wdata", 64'(b.dmem_wdata), 64'd0);
    chk("rst_be", 64'(b.dmem_byte_en), 64'd0);
    chk("rst_dones", 64'({b.c_done, b.a_done}), 64'd0);
    chk("rst_rdata", 64'({b.c_rdata, b.a_rdata}), 64'd0);
    chk("rst_stall", 64'(b.core_stall), 64'(b.c_req));
    b.c_req = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    ready_idle = 1'b1;
    @(negedge clk);
    chk("idle_ready_ignored", 64'(b.c_done | b.a_done | strobe), 64'd0);
    tick();
    b.c_req = 1'b1; b.c_wen = 1'b1; b.c_addr = 32'h100; b.c_wdata = 32'hDEADBEEF; b.c_byte_en = 4'hF;
    push(1'b0, 32'h100, 1'b1);
    @(negedge clk);
    chk("st_stall_idle", 64'(b.core_stall), 64'd1);
    chk("st_wen_idle", 64'(b.dmem_wen), 64'd0);
    @(negedge clk);
    chk("st_wen", 64'(b.dmem_wen), 64'd1);
    chk("st_ren", 64'(b.dmem_ren), 64'd0);
    chk("st_addr", 64'(b.dmem_addr), 64'h100);
    chk("st_wdata", 64'(b.dmem_wdata), 64'hDEADBEEF);
    chk("st_be", 64'(b.dmem_byte_en), 64'hF);
    chk("st_c_done", 64'(b.c_done), 64'd1);
    chk("st_stall_done", 64'(b.core_stall), 64'd0);
    tick();
    b.c_req = 1'b0;
    @(negedge clk);
    chk("st_back_idle", 64'(strobe), 64'd0);
    tick();
    ready_idle = 1'b0; lat = 3; ren_cnt = 0;
    b.a_req = 1'b1; b.a_wen = 1'b0; b.a_addr = 32'h40; b.a_byte_en = 4'hF;
    push(1'b1, 32'h40, 1'b0);
    wait_done(pushed, 20);
    b.a_req = 1'b0;
    tick();
    tick();
    chk("ld_ren_cycles", 64'(ren_cnt), 64'd4);
    chk("ld_single_done", 64'(done_cnt), 64'(pushed));
    lat = 0;
    b.c_req = 1'b1; b.c_wen = 1'b1; b.c_addr = 32'h180; b.c_wdata = 32'hCAFEF00D; b.c_byte_en = 4'h3;
    b.a_req = 1'b1; b.a_wen = 1'b0; b.a_addr = 32'h44; b.a_byte_en = 4'hF;
    push(1'b0, 32'h180, 1'b1);
    push(1'b1, 32'h44, 1'b0);
    wait_done(pushed - 1, 10);
    b.c_req = 1'b0;
    wait_done(pushed, 10);
    b.a_req = 1'b0;
    tick();
    b.c_req = 1'b1; b.c_wen = 1'b0; b.c_addr = 32'h200; b.c_byte_en = 4'hF;
    b.a_req = 1'b1; b.a_wen = 1'b1; b.a_addr = 32'h300; b.a_wdata = 32'h55AA55AA; b.a_byte_en = 4'hF;
    for (int r = 0; r < 2; r++) begin
      repeat (4) push(1'b0, 32'h200, 1'b0);
      push(1'b1, 32'h300, 1'b1);
    end
    wait_done(pushed, 60);
    b.c_req = 1'b0;
    b.a_req = 1'b0;
    tick();
    lat = 2;
    b.a_req = 1'b1; b.a_wen = 1'b0; b.a_addr = 32'h48;
    push(1'b1, 32'h48, 1'b0);
    tick();
    b.a_req = 1'b0;
    @(negedge clk);
    chk("wd_still_busy", 64'(b.dmem_ren), 64'd1);
    wait_done(pushed, 10);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("wd_no_regrant", 64'(strobe), 64'd0);
    end
    tick();
    ready_hold = 1'b1;
    b.c_req = 1'b1; b.c_wen = 1'b1; b.c_addr = 32'h1C0; b.c_wdata = 32'h13579BDF; b.c_byte_en = 4'hF;
    tick();
    chk("rs_busy", 64'(b.dmem_wen), 64'd1);
    #3 rst_n = 1'b0;
    #1;
    chk("rs_wen", 64'(b.dmem_wen | b.dmem_ren), 64'd0);
    chk("rs_addr", 64'(b.dmem_addr), 64'd0);
    chk("rs_wdata", 64'(b.dmem_wdata), 64'd0);
    chk("rs_be", 64'(b.dmem_byte_en), 64'd0);
    chk("rs_done", 64'({b.c_done, b.a_done, b.c_rdata}), 64'd0);
    chk("rs_stall", 64'(b.core_stall), 64'd1);
    b.c_req = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    ready_hold = 1'b0; lat = 0;
    tick();
    b.c_req = 1'b1; b.c_wen = 1'b0; b.c_addr = 32'h1C4;
    push(1'b0, 32'h1C4, 1'b0);
    wait_done(pushed, 10);
    b.c_req = 1'b0;
    tick();
    tick();
    chk("sb_drained", 64'(sb.size()), 64'd0);
    chk("total_dones", 64'(done_cnt), 64'd16);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
